// File: rtl/apb_master_arb.sv
// apb_master_arb: two-requester round-robin arbiter driving a single APB master port.
//
// A request is sampled only in IDLE. The winner's address, write data and direction
// are latched, and the FSM then runs SETUP (psel) followed by ACCESS (psel+penable)
// until the slave returns pready. Completion is reported one cycle later, in IDLE, by a
// one-hot done pulse. rdata carries the captured read data; it is 0 for writes.
//
// Optional feature, enabled by defining APB_TIMEOUT_EN:
//   An ACCESS wait-state counter is built. After TIMEOUT_CYC cycles with pready low,
//   the transfer is aborted and done pulses with err=1 and rdata=0. When the macro is
//   not defined there is no counter, ACCESS waits indefinitely, and err is tied to 0.
//
// Ports:
//   pclk, rst_n          clock; synchronous active-low reset
//   req[1:0]             per-requester level request
//   req_write[1:0]       per-requester direction (1 = write)
//   req_addr, req_wdata  requester i fields at [i*W +: W]
//   gnt[1:0]             one-hot pulse during SETUP: request accepted and latched
//   done[1:0]            one-hot pulse in the cycle after completion
//   rdata, err           qualified by done
//   paddr, pwrite, pwdata, psel, penable   APB master outputs
//   pready, prdata                         APB slave responses
module apb_master_arb #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic [ADDR_W-1:0]   paddr,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  output logic                psel,
  output logic                penable,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata
);

  // A zero limit would make every access abort before it could complete.
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout_cfg
    $error("apb_master_arb: TIMEOUT_CYC must be non-zero");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state, state_d;
  logic                last, last_d;      // requester that most recently completed
  logic                owner, owner_d;    // requester of the transfer in flight
  logic                win_c;
  logic [1:0]          gnt_d, done_d;
  logic [DATA_W-1:0]   rdata_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic                pwrite_d;
  logic [DATA_W-1:0]   pwdata_d;
  logic                psel_d, penable_d;
  logic                abort_c;           // ACCESS wait limit reached this cycle
  logic                err_d;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [TCNT_W-1:0] tcnt, tcnt_d;

  // Wait-state counter: cleared in SETUP so it is zero on entering ACCESS.
  always_comb begin
    tcnt_d = tcnt;
    if (state == SETUP) begin
      tcnt_d = '0;
    end else if (state == ACCESS && !pready) begin
      tcnt_d = tcnt + TCNT_W'(1);
    end
  end

  assign abort_c = (state == ACCESS) && !pready && (tcnt == TCNT_W'(TIMEOUT_CYC - 1));
`else
  assign abort_c = 1'b0;
`endif

  // Round-robin pick: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    win_c = 1'b0;
    unique case (req)
      2'b01:   win_c = 1'b0;
      2'b10:   win_c = 1'b1;
      2'b11:   win_c = ~last;
      default: win_c = 1'b0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    last_d   = last;
    owner_d  = owner;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    rdata_d  = '0;
    err_d    = 1'b0;
    paddr_d  = paddr;
    pwrite_d = pwrite;
    pwdata_d = pwdata;

    unique case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_d  = SETUP;
          owner_d  = win_c;
          gnt_d    = win_c ? 2'b10 : 2'b01;
          paddr_d  = win_c ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
          pwdata_d = win_c ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          pwrite_d = win_c ? req_write[1] : req_write[0];
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          state_d = IDLE;
          last_d  = owner;
          done_d  = owner ? 2'b10 : 2'b01;
          rdata_d = pwrite ? '0 : prdata;
        end else if (abort_c) begin
          state_d = IDLE;
          last_d  = owner;
          done_d  = owner ? 2'b10 : 2'b01;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  // State and registered outputs.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;   // requester 0 takes the first contended grant
      owner   <= 1'b0;
      gnt     <= 2'b00;
      done    <= 2'b00;
      rdata   <= '0;
      paddr   <= '0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
    end else begin
      state   <= state_d;
      last    <= last_d;
      owner   <= owner_d;
      gnt     <= gnt_d;
      done    <= done_d;
      rdata   <= rdata_d;
      paddr   <= paddr_d;
      pwrite  <= pwrite_d;
      pwdata  <= pwdata_d;
      psel    <= psel_d;
      penable <= penable_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  // Timeout counter and error flag.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      tcnt <= tcnt_d;
      err  <= err_d;
    end
  end
`else
  assign err = 1'b0;

  // err_d has no consumer without the timeout feature.
  logic unused_err_c;
  assign unused_err_c = err_d;
`endif

endmodule

// File: tb/tb_apb_master_arb.sv
// Scoreboard bench for apb_master_arb: stimulus pushes expected grants and completions,
// and a monitor pops and compares them whenever gnt or done is presented.
module tb_apb_master_arb;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          pclk = 1'b0;
  logic          rst_n;
  logic [1:0]    req, req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    gnt, done;
  logic [DW-1:0] rdata;
  logic          err;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          psel, penable;
  logic          pready;
  logic [DW-1:0] prdata;

  apb_master_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .pclk(pclk), .rst_n(rst_n), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rdata(rdata), .err(err), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .psel(psel), .penable(penable), .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [1:0]    g;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic          w;
  } gexp_t;

  typedef struct packed {
    logic [1:0]    d;
    logic [DW-1:0] rd;
    logic          e;
  } dexp_t;

  gexp_t exp_gnt[$];
  dexp_t exp_done[$];
  gexp_t cur;
  bit    have_cur = 1'b0;
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  // Monitor: compares every presented grant and completion against the queues.
  always @(negedge pclk) begin
    gexp_t ge;
    dexp_t de;
    if (!rst_n) have_cur = 1'b0;
    if (gnt != 2'b00) begin
      tests++;
      if (exp_gnt.size() == 0) begin
        fails++;
        $display("FAIL gnt_unexpected got gnt=%b", gnt);
      end else begin
        ge = exp_gnt.pop_front();
        if (gnt !== ge.g || paddr !== ge.a || pwrite !== ge.w || pwdata !== ge.wd ||
            psel !== 1'b1 || penable !== 1'b0) begin
          fails++;
          $display("FAIL gnt_setup got gnt=%b addr=%h w=%b wd=%h sel=%b en=%b exp gnt=%b addr=%h w=%b wd=%h sel=1 en=0",
                   gnt, paddr, pwrite, pwdata, psel, penable, ge.g, ge.a, ge.w, ge.wd);
        end
        cur = ge;
        have_cur = 1'b1;
      end
    end else if (psel && have_cur) begin
      tests++;
      if (paddr !== cur.a || pwrite !== cur.w || pwdata !== cur.wd || penable !== 1'b1) begin
        fails++;
        $display("FAIL access_hold got addr=%h w=%b wd=%h en=%b exp addr=%h w=%b wd=%h en=1",
                 paddr, pwrite, pwdata, penable, cur.a, cur.w, cur.wd);
      end
    end
    if (done != 2'b00) begin
      tests++;
      have_cur = 1'b0;
      if (exp_done.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected got done=%b", done);
      end else begin
        de = exp_done.pop_front();
        if (done !== de.d || rdata !== de.rd || err !== de.e || psel !== 1'b0 || penable !== 1'b0) begin
          fails++;
          $display("FAIL done_resp got done=%b rdata=%h err=%b sel=%b en=%b exp done=%b rdata=%h err=%b sel=0 en=0",
                   done, rdata, err, psel, penable, de.d, de.rd, de.e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (gnt != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL gnt_timeout got no grant in 20 cycles exp a grant");
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk);
      if (done != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL done_timeout got no done in 40 cycles exp a done");
    end
  endtask

  // One transfer by requester idx with waitn ACCESS wait states.
  task automatic xfer(input int idx, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input int waitn, input logic [DW-1:0] pr);
    gexp_t g;
    dexp_t d;
    int    pen;
    bit    ok;
    g.g  = (idx == 1) ? 2'b10 : 2'b01;
    g.a  = a;
    g.wd = wd;
    g.w  = wr;
    d.d  = g.g;
    d.rd = wr ? '0 : pr;
    d.e  = 1'b0;
    exp_gnt.push_back(g);
    exp_done.push_back(d);
    req_addr[idx*AW +: AW]  = a;
    req_wdata[idx*DW +: DW] = wd;
    req_write[idx] = wr;
    prdata = pr;
    pready = 1'b0;
    req[idx] = 1'b1;
    wait_gnt(ok);
    req = 2'b00;
    if (!ok) return;
    pen = 0;
    repeat (waitn) begin
      @(negedge pclk);
      if (penable) pen++;
    end
    @(negedge pclk);
    if (penable) pen++;
    pready = 1'b1;
    @(negedge pclk);
    pready = 1'b0;
    chk("penable_cycles", 64'(pen), 64'(waitn + 1));
    chk("done_latency", 64'(done), 64'(g.g));
  endtask

  initial begin
    gexp_t g;
    dexp_t d;
    bit    ok;
    int    gc[4];
    int    pen;
    int    bad;

    rst_n = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    pready = 1'b0; prdata = '0;
    repeat (2) @(negedge pclk);
    chk("rst_psel", 64'(psel), 0);
    chk("rst_penable", 64'(penable), 0);
    chk("rst_pwrite", 64'(pwrite), 0);
    chk("rst_paddr", 64'(paddr), 0);
    chk("rst_pwdata", 64'(pwdata), 0);
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_rdata", 64'(rdata), 0);
    chk("rst_err", 64'(err), 0);
    rst_n = 1'b1;
    @(negedge pclk);

    // Single write, read with wait states, write with read data present, zero-wait read.
    xfer(0, 1'b1, 32'h10, 32'hA5A5A5A5, 0, 32'h0);
    xfer(1, 1'b0, 32'h20, 32'h0, 3, 32'h12345678);
    xfer(1, 1'b1, 32'h24, 32'h0F0F1234, 1, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h2C, 32'h0, 0, 32'hCAFEF00D);

    // Contention from reset: grants alternate starting with requester 0, every 3 cycles.
    rst_n = 1'b0;
    req = 2'b11; req_write = 2'b00;
    req_addr = {32'h200, 32'h100}; req_wdata = {32'h2, 32'h1};
    prdata = 32'h55AA1234; pready = 1'b1;
    repeat (2) @(negedge pclk);
    for (int k = 0; k < 4; k++) begin
      g.g  = (k % 2 == 0) ? 2'b01 : 2'b10;
      g.a  = (k % 2 == 0) ? 32'h100 : 32'h200;
      g.wd = (k % 2 == 0) ? 32'h1 : 32'h2;
      g.w  = 1'b0;
      d.d  = g.g; d.rd = 32'h55AA1234; d.e = 1'b0;
      exp_gnt.push_back(g);
      exp_done.push_back(d);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(ok);
      gc[k] = cyc;
      if (k == 3) req = 2'b00;
    end
    wait_done();
    pready = 1'b0;
    chk("rr_spacing_1", 64'(gc[1] - gc[0]), 3);
    chk("rr_spacing_2", 64'(gc[2] - gc[1]), 3);
    chk("rr_spacing_3", 64'(gc[3] - gc[2]), 3);
    @(negedge pclk);

    // Reset mid-transfer: no done, and priority returns to requester 0.
    xfer(0, 1'b1, 32'h30, 32'h11111111, 0, 32'h0);
    g.g = 2'b10; g.a = 32'h50; g.wd = 32'h0; g.w = 1'b0;
    exp_gnt.push_back(g);
    req_addr[AW +: AW] = 32'h50; req_wdata[DW +: DW] = '0; req_write = 2'b00;
    pready = 1'b0;
    req = 2'b10;
    wait_gnt(ok);
    req = 2'b00;
    repeat (2) @(negedge pclk);
    chk("mid_in_access", 64'(penable), 1);
    rst_n = 1'b0;
    @(negedge pclk);
    chk("mid_rst_psel", 64'(psel), 0);
    chk("mid_rst_penable", 64'(penable), 0);
    chk("mid_rst_done", 64'(done), 0);
    rst_n = 1'b1;
    req_addr = {32'h70, 32'h60}; req_wdata = '0; req_write = 2'b00;
    prdata = 32'h0BADCAFE; pready = 1'b1;
    g.g = 2'b01; g.a = 32'h60; g.wd = 32'h0; g.w = 1'b0;
    d.d = 2'b01; d.rd = 32'h0BADCAFE; d.e = 1'b0;
    exp_gnt.push_back(g);
    exp_done.push_back(d);
    req = 2'b11;
    wait_gnt(ok);
    req = 2'b00;
    wait_done();
    pready = 1'b0;
    @(negedge pclk);

    // Slave never ready.
    req_addr[AW-1:0] = 32'h40; req_wdata[DW-1:0] = '0; req_write = 2'b00;
    prdata = 32'hFFFFFFFF; pready = 1'b0;
    g.g = 2'b01; g.a = 32'h40; g.wd = 32'h0; g.w = 1'b0;
    exp_gnt.push_back(g);
`ifdef APB_TIMEOUT_EN
    d.d = 2'b01; d.rd = '0; d.e = 1'b1;
    exp_done.push_back(d);
`endif
    req = 2'b01;
    wait_gnt(ok);
    req = 2'b00;
`ifdef APB_TIMEOUT_EN
    pen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pclk);
      if (done != 2'b00) break;
      if (penable) pen++;
    end
    chk("timeout_access_cycles", 64'(pen), 64'(TO));
    chk("timeout_done", 64'(done), 1);
    chk("timeout_psel", 64'(psel), 0);
`else
    pen = 0;
    bad = 0;
    repeat (100) begin
      @(negedge pclk);
      if (!psel || done != 2'b00) bad++;
    end
    chk("no_timeout_hold", 64'(bad), 0);
    rst_n = 1'b0;
    @(negedge pclk);
    rst_n = 1'b1;
    chk("no_timeout_rst_psel", 64'(psel), 0);
`endif
    @(negedge pclk);

    chk("gnt_queue_empty", 64'(exp_gnt.size()), 0);
    chk("done_queue_empty", 64'(exp_done.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got time limit exp bench completion");
    $fatal(1, "watchdog");
  end

endmodule
